prco_decoder_pipe: RTL and testbench
====================================

Name: prco_decoder_pipe

Overview:
Parametrised, pipelined successor to the PRCO instruction decoder. It sits between fetch and the ALU/RAM/UART execute stages and replaces the i_ce/q_ce/q_fetch pulse protocol with a valid/ready handshake backed by a one-entry skid buffer. It adds pipeline flush, a sticky halt with input back-pressure, an explicit illegal-opcode flag and a decoded-instruction counter. Field positions and widths are set by parameters.

Parameters:
INSTR_W, 16, instruction width
OP_W, 5, opcode width at bits [INSTR_W-1 -: OP_W]
SEL_W, 3, register select width; Rd at [INSTR_W-OP_W-1 -: SEL_W], Ra at [7:5], Rb at [4:2] for the default layout
IMM_W, 8, unsigned immediate width, taken from [IMM_W-1:0]
SIMM_W, 5, signed immediate width, taken from [SIMM_W-1:0]
COUNT_W, 16, width of the decoded-instruction counter

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-low reset
i_valid  in  1  i_instr is valid
q_ready  out  1  decoder can accept; registered, equals ~skid_full
i_instr  in  INSTR_W  instruction from fetch
i_flush  in  1  discard all held and incoming instructions
q_valid  out  1  decoded bundle is valid
i_ready  in  1  execute accepts the bundle
q_op  out  OP_W  opcode
q_seld, q_sela, q_selb  out  SEL_W each  register selects
q_third_sel  out  1  instruction uses three register selects
q_imm8  out  IMM_W  unsigned immediate
q_simm5  out  SIMM_W  signed immediate
q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data  out  1 each  execute requests
q_illegal  out  1  opcode not in the ISA
q_halt  out  1  sticky halt
q_count  out  COUNT_W  number of completed output handshakes

Behaviour:
- Reset (i_reset==0 at the clock edge) overrides all other inputs. Every output and the skid buffer clear to 0. q_ready reads 1 from the first cycle after reset is released.
- Accept condition: i_valid & q_ready & ~i_flush & ~q_halt.
- Output handshake: q_valid & i_ready. On each handshake, q_count increments and wraps modulo 2^COUNT_W.
- Latency: an instruction accepted at edge N is presented at edge N with q_valid=1, provided the output register is empty or is handshaking in that same cycle.
- If the output register is held (q_valid & ~i_ready) when an instruction is accepted, the instruction goes to the skid buffer and q_ready falls at the next edge. On the next output handshake, the skid entry moves to the output register and q_ready returns to 1. No instruction is ever dropped or duplicated.
- Decoding is combinational on the instruction being loaded; the decoded bundle is registered alongside it.
  - q_op, q_seld, q_imm8 and q_simm5 are fixed bit slices.
  - q_selb = [4:2]. q_third_sel = 0 for every current opcode.
  - q_sela = [10:8] for PRCO_OP_SET; [7:5] otherwise.
- Per-opcode control flags:
  - NOP: all flags 0.
  - MOVI, MOV, ADD, ADDI, SUBI: reg_we=1, req_alu=1.
  - LW: reg_we=1, req_ram=1.
  - SW: req_ram=1, req_ram_we=1.
  - CMP: req_alu=1.
  - JMP: reg_we=1, req_alu=1.
  - SET: reg_we=1, req_alu=1.
  - WRITE: new_uart1_data=1.
  - Any other opcode: q_illegal=1, all other flags 0.
- Halt: when an illegal instruction is loaded into the output register, q_halt sets at the same edge and stays set until reset.
  - While q_halt=1, q_ready=0 and any skid entry is frozen.
  - The illegal instruction is still presented and may complete its handshake.
- Flush: i_flush=1 at an edge clears q_valid and the skid buffer, discards any input offered that cycle and sets q_ready=1.
  - Flush does not clear q_halt or q_count.
  - A handshake completing in the flush cycle still counts.
- Simultaneous events: reset > flush > halt > normal operation.

Test Plan:
- Reset: hold i_reset=0 for 2 cycles with i_valid=1 -> all outputs 0; q_ready=1 on the first cycle after release; q_count=0.
- Streaming: with i_ready=1, send MOVI (Rd=3, imm=8'hA5), LW (Rd=1, Ra=2, simm=5'h04), SW -> one bundle per cycle at 1-cycle latency.
  - MOVI: q_seld=3, q_imm8=A5, q_reg_we=1.
  - LW: q_req_ram=1, q_sela=2, q_simm5=04.
  - SW: q_req_ram_we=1.
  - q_count=3 at the end.
- Back-pressure: hold i_ready=0 while offering 3 instructions -> 2 are accepted, q_ready=0 from the second acceptance. Releasing i_ready delivers them in order, then q_ready=1. No loss.
- SET select: SET with [10:8]=5 and [7:5]=2 -> q_sela=5, q_seld=5, q_reg_we=1.
- Illegal opcode: an unused opcode followed by ADD -> the illegal bundle appears with q_illegal=1 and q_halt=1. q_ready stays 0 for the next 20 cycles, ADD is never presented, and q_count increments by exactly 1.
- Flush: flush while both the output register and skid buffer are full -> q_valid=0 and q_ready=1 at the next edge. The next instruction sent appears alone and q_count is unchanged by the flush.

Source files
------------

// File: rtl/prco_decoder_pipe.sv
// -----------------------------------------------------------------------------
// prco_decoder_pipe
//
// Pipelined PRCO instruction decoder between fetch and the execute stages.
// An instruction taken from fetch is decoded combinationally and registered
// together with its decoded bundle in one output register. A one-entry skid
// buffer absorbs the instruction that arrives while execute is stalling, so
// q_ready can be a plain register output. An illegal opcode raises a sticky
// halt that stops further intake until reset.
//
// Ports
//   i_clk              clock
//   i_reset            synchronous, active-low reset
//   i_valid / q_ready  fetch-side handshake; q_ready is registered
//   i_instr            instruction from fetch
//   i_flush            drop the held bundle, the skid entry and this cycle's input
//   q_valid / i_ready  execute-side handshake
//   q_op, q_seld, q_sela, q_selb, q_third_sel, q_imm8, q_simm5
//                      decoded fields of the presented instruction
//   q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data
//                      execute requests for the presented instruction
//   q_illegal          presented opcode is not part of the ISA
//   q_halt             sticky halt, set when an illegal opcode is presented
//   q_count            completed execute-side handshakes, wraps
// -----------------------------------------------------------------------------
module prco_decoder_pipe #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int SEL_W   = 3,
  parameter int IMM_W   = 8,
  parameter int SIMM_W  = 5,
  parameter int COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               q_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_flush,
  output logic               q_valid,
  input  logic               i_ready,
  output logic [OP_W-1:0]    q_op,
  output logic [SEL_W-1:0]   q_seld,
  output logic [SEL_W-1:0]   q_sela,
  output logic [SEL_W-1:0]   q_selb,
  output logic               q_third_sel,
  output logic [IMM_W-1:0]   q_imm8,
  output logic [SIMM_W-1:0]  q_simm5,
  output logic               q_reg_we,
  output logic               q_req_alu,
  output logic               q_req_ram,
  output logic               q_req_ram_we,
  output logic               q_new_uart1_data,
  output logic               q_illegal,
  output logic               q_halt,
  output logic [COUNT_W-1:0] q_count
);

  // Register-select field positions: Rd directly below the opcode, then Ra,
  // then Rb (default layout: Rd [10:8], Ra [7:5], Rb [4:2]).
  localparam int RD_MSB = INSTR_W - OP_W - 1;
  localparam int RA_MSB = RD_MSB - SEL_W;
  localparam int RB_MSB = RA_MSB - SEL_W;

  // Opcode map
  localparam logic [OP_W-1:0] PRCO_OP_NOP   = OP_W'(5'h00);
  localparam logic [OP_W-1:0] PRCO_OP_MOVI  = OP_W'(5'h01);
  localparam logic [OP_W-1:0] PRCO_OP_MOV   = OP_W'(5'h02);
  localparam logic [OP_W-1:0] PRCO_OP_ADD   = OP_W'(5'h03);
  localparam logic [OP_W-1:0] PRCO_OP_ADDI  = OP_W'(5'h04);
  localparam logic [OP_W-1:0] PRCO_OP_SUBI  = OP_W'(5'h05);
  localparam logic [OP_W-1:0] PRCO_OP_LW    = OP_W'(5'h06);
  localparam logic [OP_W-1:0] PRCO_OP_SW    = OP_W'(5'h07);
  localparam logic [OP_W-1:0] PRCO_OP_CMP   = OP_W'(5'h08);
  localparam logic [OP_W-1:0] PRCO_OP_JMP   = OP_W'(5'h09);
  localparam logic [OP_W-1:0] PRCO_OP_SET   = OP_W'(5'h0A);
  localparam logic [OP_W-1:0] PRCO_OP_WRITE = OP_W'(5'h0B);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic               valid_reg, valid_next;
  logic               ready_reg, ready_next;
  logic               halt_reg, halt_next;
  logic               skid_full_reg, skid_full_next;
  logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic [OP_W-1:0]    op_reg;
  logic [SEL_W-1:0]   seld_reg, sela_reg, selb_reg;
  logic               third_sel_reg;
  logic [IMM_W-1:0]   imm8_reg;
  logic [SIMM_W-1:0]  simm5_reg;
  logic               reg_we_reg, req_alu_reg, req_ram_reg, req_ram_we_reg;
  logic               uart_reg, illegal_reg;

  // ---------------------------------------------------------------------------
  // Handshake and steering
  // ---------------------------------------------------------------------------
  logic handshake;     // execute takes the presented bundle this cycle
  logic accept;        // fetch hands over an instruction this cycle
  logic out_free;      // output register may be overwritten at this edge
  logic load_skid;     // skid entry moves into the output register
  logic load_in;       // incoming instruction goes straight to the output
  logic load_out;      // output register loads a new bundle
  logic skid_capture;  // incoming instruction parks in the skid buffer

  assign handshake    = valid_reg & i_ready;
  assign accept       = i_valid & ready_reg & ~i_flush & ~halt_reg;
  assign out_free     = ~valid_reg | handshake;
  // A halted decoder keeps its skid entry frozen, so it never drains it.
  assign load_skid    = handshake & skid_full_reg & ~halt_reg & ~i_flush;
  assign load_in      = accept & out_free & ~skid_full_reg;
  assign load_out     = load_skid | load_in;
  assign skid_capture = accept & ~out_free;

  // ---------------------------------------------------------------------------
  // Combinational decode of the instruction being loaded
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] src_instr;
  logic [OP_W-1:0]    dec_op;
  logic [SEL_W-1:0]   dec_seld, dec_sela, dec_selb;
  logic [IMM_W-1:0]   dec_imm8;
  logic [SIMM_W-1:0]  dec_simm5;
  logic               dec_reg_we, dec_req_alu, dec_req_ram, dec_req_ram_we;
  logic               dec_uart, dec_illegal;

  always_comb begin
    src_instr      = load_skid ? skid_instr_reg : i_instr;
    dec_op         = src_instr[INSTR_W-1 -: OP_W];
    dec_seld       = src_instr[RD_MSB -: SEL_W];
    dec_selb       = src_instr[RB_MSB -: SEL_W];
    dec_imm8       = src_instr[IMM_W-1:0];
    dec_simm5      = src_instr[SIMM_W-1:0];
    dec_sela       = src_instr[RA_MSB -: SEL_W];
    dec_reg_we     = 1'b0;
    dec_req_alu    = 1'b0;
    dec_req_ram    = 1'b0;
    dec_req_ram_we = 1'b0;
    dec_uart       = 1'b0;
    dec_illegal    = 1'b0;

    case (dec_op)
      PRCO_OP_NOP: ;
      PRCO_OP_MOVI, PRCO_OP_MOV, PRCO_OP_ADD, PRCO_OP_ADDI, PRCO_OP_SUBI,
      PRCO_OP_JMP: begin
        dec_reg_we  = 1'b1;
        dec_req_alu = 1'b1;
      end
      PRCO_OP_SET: begin
        // SET reads its source from the Rd field position
        dec_sela    = src_instr[RD_MSB -: SEL_W];
        dec_reg_we  = 1'b1;
        dec_req_alu = 1'b1;
      end
      PRCO_OP_LW: begin
        dec_reg_we  = 1'b1;
        dec_req_ram = 1'b1;
      end
      PRCO_OP_SW: begin
        dec_req_ram    = 1'b1;
        dec_req_ram_we = 1'b1;
      end
      PRCO_OP_CMP:   dec_req_alu = 1'b1;
      PRCO_OP_WRITE: dec_uart    = 1'b1;
      default:       dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_next      = valid_reg;
    halt_next       = halt_reg;
    skid_full_next  = skid_full_reg;
    skid_instr_next = skid_instr_reg;
    count_next      = count_reg;
    ready_next      = ready_reg;

    // A handshake in a flush cycle still counts as delivered.
    if (handshake) begin
      count_next = count_reg + COUNT_W'(1);
    end

    if (i_flush) begin
      valid_next     = 1'b0;
      skid_full_next = 1'b0;
      // Intake reopens unless a halt is pending; flush never clears the halt.
      ready_next     = ~halt_reg;
    end else begin
      if (load_out) begin
        valid_next = 1'b1;
        if (dec_illegal) begin
          halt_next = 1'b1;
        end
      end else if (handshake) begin
        valid_next = 1'b0;
      end

      if (load_skid) begin
        skid_full_next = 1'b0;
      end else if (skid_capture) begin
        skid_full_next  = 1'b1;
        skid_instr_next = i_instr;
      end

      ready_next = ~skid_full_next & ~halt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      valid_reg      <= 1'b0;
      ready_reg      <= 1'b0;
      halt_reg       <= 1'b0;
      skid_full_reg  <= 1'b0;
      skid_instr_reg <= '0;
      count_reg      <= '0;
      op_reg         <= '0;
      seld_reg       <= '0;
      sela_reg       <= '0;
      selb_reg       <= '0;
      third_sel_reg  <= 1'b0;
      imm8_reg       <= '0;
      simm5_reg      <= '0;
      reg_we_reg     <= 1'b0;
      req_alu_reg    <= 1'b0;
      req_ram_reg    <= 1'b0;
      req_ram_we_reg <= 1'b0;
      uart_reg       <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      valid_reg      <= valid_next;
      ready_reg      <= ready_next;
      halt_reg       <= halt_next;
      skid_full_reg  <= skid_full_next;
      skid_instr_reg <= skid_instr_next;
      count_reg      <= count_next;
      if (load_out && !i_flush) begin
        op_reg         <= dec_op;
        seld_reg       <= dec_seld;
        sela_reg       <= dec_sela;
        selb_reg       <= dec_selb;
        third_sel_reg  <= 1'b0;  // no current opcode uses three selects
        imm8_reg       <= dec_imm8;
        simm5_reg      <= dec_simm5;
        reg_we_reg     <= dec_reg_we;
        req_alu_reg    <= dec_req_alu;
        req_ram_reg    <= dec_req_ram;
        req_ram_we_reg <= dec_req_ram_we;
        uart_reg       <= dec_uart;
        illegal_reg    <= dec_illegal;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign q_ready          = ready_reg;
  assign q_valid          = valid_reg;
  assign q_op             = op_reg;
  assign q_seld           = seld_reg;
  assign q_sela           = sela_reg;
  assign q_selb           = selb_reg;
  assign q_third_sel      = third_sel_reg;
  assign q_imm8           = imm8_reg;
  assign q_simm5          = simm5_reg;
  assign q_reg_we         = reg_we_reg;
  assign q_req_alu        = req_alu_reg;
  assign q_req_ram        = req_ram_reg;
  assign q_req_ram_we     = req_ram_we_reg;
  assign q_new_uart1_data = uart_reg;
  assign q_illegal        = illegal_reg;
  assign q_halt           = halt_reg;
  assign q_count          = count_reg;

endmodule

// File: tb/tb_prco_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_prco_decoder_pipe
//
// Directed bench for prco_decoder_pipe with default parameters. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// Opcode map: NOP 00, MOVI 01, MOV 02, ADD 03, ADDI 04, SUBI 05, LW 06,
// SW 07, CMP 08, JMP 09, SET 0A, WRITE 0B; everything else is illegal.
// -----------------------------------------------------------------------------
module tb_prco_decoder_pipe;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        q_ready;
  logic [15:0] i_instr;
  logic        i_flush;
  logic        q_valid;
  logic        i_ready;
  logic [4:0]  q_op;
  logic [2:0]  q_seld, q_sela, q_selb;
  logic        q_third_sel;
  logic [7:0]  q_imm8;
  logic [4:0]  q_simm5;
  logic        q_reg_we, q_req_alu, q_req_ram, q_req_ram_we, q_new_uart1_data;
  logic        q_illegal, q_halt;
  logic [15:0] q_count;

  int checks = 0;
  int errors = 0;

  prco_decoder_pipe dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .q_ready          (q_ready),
    .i_instr          (i_instr),
    .i_flush          (i_flush),
    .q_valid          (q_valid),
    .i_ready          (i_ready),
    .q_op             (q_op),
    .q_seld           (q_seld),
    .q_sela           (q_sela),
    .q_selb           (q_selb),
    .q_third_sel      (q_third_sel),
    .q_imm8           (q_imm8),
    .q_simm5          (q_simm5),
    .q_reg_we         (q_reg_we),
    .q_req_alu        (q_req_alu),
    .q_req_ram        (q_req_ram),
    .q_req_ram_we     (q_req_ram_we),
    .q_new_uart1_data (q_new_uart1_data),
    .q_illegal        (q_illegal),
    .q_halt           (q_halt),
    .q_count          (q_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Hand-encoded instructions: {op[15:11], rd[10:8], ra[7:5], rb/low[4:0]}
  localparam logic [15:0] I_MOVI  = 16'h0BA5; // 00001 011 10100101 : Rd=3 imm=A5
  localparam logic [15:0] I_LW    = 16'h3144; // 00110 001 010 00100 : Rd=1 Ra=2 simm=04
  localparam logic [15:0] I_SW    = 16'h3CBF; // 00111 100 101 11111
  localparam logic [15:0] I_ADD   = 16'h194C; // 00011 001 010 011 00 : Rb=3
  localparam logic [15:0] I_ADDI  = 16'h2211; // 00100 010 00010001
  localparam logic [15:0] I_SUBI  = 16'h2B22; // 00101 011 00100010
  localparam logic [15:0] I_SET   = 16'h5540; // 01010 101 010 00000 : [10:8]=5 [7:5]=2
  localparam logic [15:0] I_MOV   = 16'h1020; // 00010 000 001 00000
  localparam logic [15:0] I_CMP   = 16'h4120; // 01000 001 001 00000
  localparam logic [15:0] I_JMP   = 16'h4800; // 01001 000 ...
  localparam logic [15:0] I_WRITE = 16'h5E00; // 01011 110 ...
  localparam logic [15:0] I_ILL   = 16'hF800; // 11111 : unused opcode

  initial begin
    bit saw_add;

    // ---------------- reset, input offered during reset ----------------
    i_reset = 1'b0;
    i_valid = 1'b1;
    i_instr = I_MOVI;
    i_flush = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    check("rst_valid",   q_valid, 0);
    check("rst_ready",   q_ready, 0);
    check("rst_count",   q_count, 0);
    check("rst_halt",    q_halt, 0);
    check("rst_op",      q_op, 0);
    check("rst_reg_we",  q_reg_we, 0);
    check("rst_illegal", q_illegal, 0);
    i_reset = 1'b1;
    i_valid = 1'b0;
    tick();
    check("rel_ready", q_ready, 1);
    check("rel_valid", q_valid, 0);
    check("rel_count", q_count, 0);

    // ---------------- streaming ----------------
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_instr = I_MOVI;
    tick();
    check("movi_valid",  q_valid, 1);
    check("movi_op",     q_op, 5'h01);
    check("movi_seld",   q_seld, 3);
    check("movi_imm8",   q_imm8, 8'hA5);
    check("movi_reg_we", q_reg_we, 1);
    check("movi_alu",    q_req_alu, 1);
    i_instr = I_LW;
    tick();
    check("lw_valid",  q_valid, 1);
    check("lw_ram",    q_req_ram, 1);
    check("lw_ram_we", q_req_ram_we, 0);
    check("lw_sela",   q_sela, 2);
    check("lw_simm5",  q_simm5, 5'h04);
    check("lw_reg_we", q_reg_we, 1);
    check("lw_count",  q_count, 1);
    i_instr = I_SW;
    tick();
    check("sw_ram_we", q_req_ram_we, 1);
    check("sw_ram",    q_req_ram, 1);
    check("sw_reg_we", q_reg_we, 0);
    check("sw_third",  q_third_sel, 0);
    i_valid = 1'b0;
    tick();
    check("stream_count", q_count, 3);
    check("stream_idle",  q_valid, 0);

    // ---------------- back-pressure ----------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = I_ADD;
    tick();
    check("bp_first_ready", q_ready, 1);
    check("bp_add_selb",    q_selb, 3);
    i_instr = I_ADDI;
    tick();
    check("bp_second_ready", q_ready, 0);
    i_instr = I_SUBI;
    tick();
    check("bp_third_ready", q_ready, 0);
    check("bp_held_op",     q_op, 5'h03);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check("bp_drain1_op",    q_op, 5'h04);
    check("bp_drain1_valid", q_valid, 1);
    check("bp_drain1_ready", q_ready, 1);
    check("bp_drain1_count", q_count, 4);
    tick();
    check("bp_drain2_valid", q_valid, 0);
    check("bp_drain2_count", q_count, 5);

    // ---------------- SET select ----------------
    i_valid = 1'b1;
    i_instr = I_SET;
    tick();
    check("set_sela",   q_sela, 5);
    check("set_seld",   q_seld, 5);
    check("set_reg_we", q_reg_we, 1);
    i_valid = 1'b0;
    tick();
    check("set_count", q_count, 6);

    // ---------------- flush with output and skid full ----------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = I_MOV;
    tick();
    i_instr = I_CMP;
    tick();
    check("fl_pre_ready", q_ready, 0);
    check("fl_pre_op",    q_op, 5'h02);
    i_flush = 1'b1;
    i_instr = I_JMP;
    tick();
    check("fl_valid", q_valid, 0);
    check("fl_ready", q_ready, 1);
    check("fl_count", q_count, 6);
    i_flush = 1'b0;
    i_ready = 1'b1;
    i_instr = I_WRITE;
    tick();
    check("fl_next_op",   q_op, 5'h0B);
    check("fl_next_uart", q_new_uart1_data, 1);
    check("fl_next_valid", q_valid, 1);
    i_valid = 1'b0;
    tick();
    check("fl_alone_valid", q_valid, 0);
    check("fl_after_count", q_count, 7);

    // ---------------- illegal opcode and sticky halt ----------------
    i_valid = 1'b1;
    i_instr = I_ILL;
    tick();
    check("ill_valid",   q_valid, 1);
    check("ill_illegal", q_illegal, 1);
    check("ill_halt",    q_halt, 1);
    check("ill_reg_we",  q_reg_we, 0);
    check("ill_alu",     q_req_alu, 0);
    check("ill_ready",   q_ready, 0);
    i_instr = I_ADD;
    saw_add = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_ready", q_ready, 0);
      if (q_valid && q_op == 5'h03) saw_add = 1'b1;
    end
    check("halt_no_add", saw_add, 0);
    check("halt_count",  q_count, 8);
    check("halt_sticky", q_halt, 1);
    check("halt_idle",   q_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
